// File: rtl/edge_stream_parser_pkg.sv
// Shared types and constants for the day-11 edge stream parser: packet format,
// node ids, ASCII codes and parser states.
package edge_stream_parser_pkg;

  localparam int unsigned MESH_DIM_DEFAULT = 4;
  localparam int unsigned COORD_W          = $clog2(MESH_DIM_DEFAULT);
  localparam int unsigned NODE_ID_W        = 15;
  localparam int unsigned LETTER_W         = 5;

  localparam logic [7:0] ASCII_A     = 8'h61;
  localparam logic [7:0] ASCII_Z     = 8'h7a;
  localparam logic [7:0] ASCII_COLON = 8'h3a;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0a;
  localparam logic [7:0] ASCII_CR    = 8'h0d;

  typedef logic [NODE_ID_W-1:0] node_id_t;
  typedef logic [COORD_W-1:0]   coord_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_EDGE = 2'd1,
    OP_DONE = 2'd2
  } opcode_t;

  typedef struct packed {
    opcode_t  opcode;
    coord_t   dst_x;
    coord_t   dst_y;
    node_id_t src_node;
    node_id_t dst_node;
  } pkt_t;

  typedef enum logic [2:0] {
    S_SRC   = 3'd0,
    S_COLON = 3'd1,
    S_SP    = 3'd2,
    S_DST   = 3'd3,
    S_SEP   = 3'd4,
    S_SKIP  = 3'd5,
    S_FIN   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_A) && (b <= ASCII_Z);
  endfunction

endpackage

// File: rtl/edge_stream_parser_node_id_pack.sv
// Folds one ASCII letter into a shifting 15-bit node id (5 bits per letter,
// oldest letter ends up in the top field) and flags non-lowercase bytes.
module node_id_pack
  import edge_stream_parser_pkg::*;
(
  input  node_id_t   id_in,
  input  logic [7:0] char_in,
  output node_id_t   id_out,
  output logic       bad_char
);

  logic [LETTER_W-1:0] letter;

  always_comb begin
    letter   = LETTER_W'(char_in - ASCII_A);
    bad_char = !is_lower(char_in);
    id_out   = {id_in[NODE_ID_W-LETTER_W-1:0], letter};
  end

endmodule

// File: rtl/edge_stream_parser.sv
// Ingress parser: turns "abc: def ghi\n" lines into EDGE packets addressed to the
// source node's home bank, then emits a DONE packet after the last input byte.
module edge_stream_parser
  import edge_stream_parser_pkg::*;
#(
  parameter int unsigned MESH_DIMENSION = MESH_DIM_DEFAULT,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output pkt_t             out_pkt,
  output logic             err,
  output logic [CNT_W-1:0] edge_count,
  output logic             done
);

  localparam int unsigned L          = $clog2(MESH_DIMENSION);
  localparam node_id_t    COORD_MASK = node_id_t'((1 << L) - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  node_id_t         acc_q, acc_d;
  node_id_t         src_q, src_d;
  logic             out_valid_q, out_valid_d;
  pkt_t             out_pkt_q, out_pkt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             live_q;

  node_id_t packed_id;
  logic     bad_char;
  logic     accept, out_fire, reg_free;
  logic     parse_err, load_edge, load_done;

  node_id_pack u_pack (
    .id_in    (acc_q),
    .char_in  (in_byte),
    .id_out   (packed_id),
    .bad_char (bad_char)
  );

  always_comb begin
    out_fire = out_valid_q && out_ready;
    reg_free = !out_valid_q || out_ready;
    in_ready = live_q && reg_free && (state_q != S_FIN) && (state_q != S_DONE);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    src_d     = src_q;
    err_d     = err_q;
    done_d    = done_q;
    parse_err = 1'b0;
    load_edge = 1'b0;
    load_done = 1'b0;

    if (accept && (in_byte != ASCII_CR)) begin
      unique case (state_q)
        S_SRC: begin
          if ((in_byte == ASCII_LF) && (idx_q == 2'd0)) begin
            // blank line
          end else if (bad_char) begin
            parse_err = 1'b1;
          end else begin
            acc_d = packed_id;
            if (idx_q == 2'd2) begin
              src_d   = packed_id;
              idx_d   = 2'd0;
              state_d = S_COLON;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        S_COLON: begin
          if (in_byte == ASCII_COLON) state_d = S_SP;
          else                        parse_err = 1'b1;
        end
        S_SP: begin
          if (in_byte == ASCII_SPACE) begin
            state_d = S_DST;
            idx_d   = 2'd0;
          end else begin
            parse_err = 1'b1;
          end
        end
        S_DST: begin
          if (bad_char) begin
            parse_err = 1'b1;
          end else begin
            acc_d = packed_id;
            if (idx_q == 2'd2) begin
              load_edge = 1'b1;
              idx_d     = 2'd0;
              state_d   = S_SEP;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        S_SEP: begin
          if (in_byte == ASCII_SPACE)   state_d = S_DST;
          else if (in_byte == ASCII_LF) state_d = S_SRC;
          else                          parse_err = 1'b1;
        end
        S_SKIP: begin
          if (in_byte == ASCII_LF) state_d = S_SRC;
        end
        default: ;
      endcase

      if (parse_err) begin
        err_d   = 1'b1;
        idx_d   = 2'd0;
        state_d = S_SKIP;
      end
    end

    // The last byte is parsed first; whatever line state it leaves behind decides
    // whether the file ended mid-line. S_SEP counts as complete (no trailing \n).
    if (accept && in_last) begin
      if (((state_d == S_SRC) && (idx_d != 2'd0)) ||
          (state_d inside {S_COLON, S_SP, S_DST}))
        err_d = 1'b1;
      state_d = S_FIN;
      idx_d   = 2'd0;
    end

    if (state_q == S_FIN) begin
      if (out_valid_q && (out_pkt_q.opcode == OP_DONE)) begin
        if (out_ready) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end else if (reg_free) begin
        load_done = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    cnt_d       = cnt_q;

    if (out_fire) out_valid_d = 1'b0;

    if (load_edge) begin
      out_valid_d        = 1'b1;
      out_pkt_d          = '0;
      out_pkt_d.opcode   = OP_EDGE;
      out_pkt_d.dst_x    = coord_t'(src_q & COORD_MASK);
      out_pkt_d.dst_y    = coord_t'((src_q >> L) & COORD_MASK);
      out_pkt_d.src_node = src_q;
      out_pkt_d.dst_node = packed_id;
    end else if (load_done) begin
      out_valid_d      = 1'b1;
      out_pkt_d        = '0;
      out_pkt_d.opcode = OP_DONE;
    end

    if (out_fire && (out_pkt_q.opcode == OP_EDGE) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SRC;
      idx_q       <= '0;
      acc_q       <= '0;
      src_q       <= '0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      src_q       <= src_d;
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      live_q      <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pkt    = out_pkt_q;
  assign err        = err_q;
  assign edge_count = cnt_q;
  assign done       = done_q;

endmodule

// File: doc/edge_stream_parser.md
# edge_stream_parser

Upstream ingress stage of the day-11 mesh: accepts the puzzle input as a raw ASCII byte stream, parses lines of the form `abc: def ghi\n` and emits one edge packet per (source, destination) pair into the mesh IO port (`io_in_pkt`). Each packet is addressed to the home bank of its source node. A final DONE packet marks end of input. The block also keeps sticky error and edge-count status for the host.

## Interface
Parameters
- `MESH_DIMENSION`, default from `parameters` package (4): mesh side length; must be a power of two.
- `CNT_W`, default 16: width of the edge counter.

Ports
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_byte`  in  8  ASCII character.
- `in_last`  in  1  qualifies the final byte of the file.
- `out_valid`  out  1  drives mesh `io_valid_in`.
- `out_ready`  in  1  from mesh `io_ready_in`.
- `out_pkt`  out  pkt_t  drives mesh `io_in_pkt`.
- `err`  out  1  sticky parse error.
- `edge_count`  out  CNT_W  edges emitted; saturates at all-ones.
- `done`  out  1  high once the DONE packet has been accepted.

## Operation
- Node id: 3 lowercase letters packed 5 bits each, first letter in bits [14:10]; id = (c0-'a')<<10 | (c1-'a')<<5 | (c2-'a').
- Home bank: `dst_x = id[L-1:0]`, `dst_y = id[2L-1:L]`, where L = log2(MESH_DIMENSION).
- pkt_t fields driven: `opcode` (EDGE=1, DONE=2), `dst_x`, `dst_y`, `src_node`, `dst_node`. DONE has all other fields 0 and is addressed to (0,0).
- FSM states:
  - S_SRC: collect 3 letters, then go to S_COLON.
  - S_COLON: expect `:`, then S_SP.
  - S_SP: expect space, then S_DST.
  - S_DST: collect 3 letters; on the third, load an EDGE packet into the output register and go to S_SEP.
  - S_SEP: space goes to S_DST; `\n` goes to S_SRC.
  - S_SKIP: discard bytes until `\n`, then S_SRC.
  - S_FIN: DONE packet pending.
  - S_DONE: terminal.
- `\r` is ignored in every state.
- `\n` while in S_SRC with 0 letters collected (blank line) is ignored.
- Any other unexpected byte sets `err`, drops the partial line and goes to S_SKIP. Edges already emitted from that line stand.
- `in_last` on an accepted byte: the byte is processed first, then the FSM enters S_FIN. DONE is loaded once the output register is free; once it is accepted, `done`=1 and the FSM enters S_DONE. A partial (incomplete) line at `in_last` sets `err`.
- `edge_count` increments on each accepted EDGE packet (`out_valid && out_ready && opcode==EDGE`).

## Timing
- Reset values: `in_ready`=0 during reset and 1 after; `out_valid`=0; `out_pkt`=0; `err`=0; `edge_count`=0; `done`=0; state S_SRC; letter index 0.
- Output is a single registered stage. The third dst letter accepted in cycle N gives `out_valid`=1 in cycle N+1.
- `in_ready` = !(out_valid && !out_ready) && state ∉ {S_FIN, S_DONE}. This gives one byte per cycle at full throughput when the mesh never stalls.
- `out_pkt` and `out_valid` hold stable while `out_valid && !out_ready`.
- Simultaneous output accept and new load in the same cycle: the register is reloaded and `out_valid` stays 1.
- Reset asserted mid-line or mid-handshake: all state clears immediately; the pending packet is lost.
- In S_DONE, `in_ready`=0 permanently until reset.

## Structure
- Add to `types`: `opcode_t` enum (EDGE, DONE), `node_id_t` (15 bits), and the pkt_t fields above.
- Add to `parameters`: `NODE_ID_W`=15 and ASCII constants.
- One sub-module, `node_id_pack`: folds a letter into the shifting 15-bit id and flags non-lowercase bytes.

## Test plan
- `aaa: bbb\n` then `in_last`, MESH_DIMENSION=4 -> EDGE src=0, dst=1057, x=0, y=0. Then DONE; `edge_count`=1, `done`=1.
- `you: out\n` -> EDGE src=25044, dst=14995, x=0, y=1.
- `abc: def ghi jkl\n` with `out_ready` low for 5 cycles after the first packet -> 3 EDGE packets in order, stable while stalled, `in_ready` low during the stall, `edge_count`=3.
- `ab1: ccc\nddd: eee\n` -> `err`=1; exactly one EDGE packet (ddd→eee).
- `\r\n` line endings and blank lines -> same packets as the plain `\n` input; `err`=0.
- Reset pulse between the 2nd and 3rd dst letter -> no packet; all outputs return to their reset values; the next line parses cleanly.
